// File: rtl/mem_stage_ext.sv
// Data-memory stage: word-organised RAM with byte/half/word stores and loads,
// sign/zero extension, alignment and range fault detection, and W-side output hold.
module mem_stage_ext #(
    parameter int unsigned AW = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReqM,
    input  logic        MemWriteM,
    input  logic [1:0]  MemSizeM,
    input  logic        MemSignedM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    input  logic        StallW,
    output logic [31:0] ReadDataW,
    output logic        LoadValidW,
    output logic        MemFaultW,
    output logic [31:0] FaultAddrW
);

    localparam int unsigned Depth = 2 ** AW;

    logic [31:0]   mem_q [Depth];

    logic          accept;
    logic          misalign;
    logic          out_of_range;
    logic          fault;
    logic          do_store;
    logic          do_load;
    logic [AW-1:0] word_idx;
    logic [1:0]    lane;
    logic [3:0]    byte_en;
    logic [31:0]   wr_data;

    logic [31:0]   rd_word_q;
    logic [1:0]    rd_lane_q;
    logic [1:0]    rd_size_q;
    logic          rd_signed_q;
    logic          load_valid_q, load_valid_d;
    logic          fault_q, fault_d;
    logic [31:0]   fault_addr_q;

    logic [7:0]    sel_byte;
    logic [15:0]   sel_half;
    logic [31:0]   ext_data;

    // Request decode, fault detection and per-lane write enables
    always_comb begin
        lane     = ALUOutM[1:0];
        word_idx = ALUOutM[AW+1:2];
        unique case (MemSizeM)
            2'b00:   misalign = 1'b0;
            2'b01:   misalign = ALUOutM[0];
            2'b10:   misalign = |ALUOutM[1:0];
            default: misalign = 1'b1;
        endcase
        out_of_range = (ALUOutM >> (AW + 2)) != 32'd0;
        fault        = misalign | out_of_range;
        accept       = MemReqM & ~StallW & ~reset;
        do_store     = accept & MemWriteM & ~fault;
        do_load      = accept & ~MemWriteM & ~fault;
        load_valid_d = do_load;
        fault_d      = accept & fault;

        byte_en = 4'b0000;
        wr_data = WriteDataM;
        unique case (MemSizeM)
            2'b00: begin
                byte_en = 4'b0001 << lane;
                wr_data = {4{WriteDataM[7:0]}};
            end
            2'b01: begin
                byte_en = lane[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{WriteDataM[15:0]}};
            end
            2'b10:   byte_en = 4'b1111;
            default: byte_en = 4'b0000;
        endcase
    end

    // RAM is deliberately not reset
    always_ff @(posedge clk) begin
        if (do_store) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem_q[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_word_q    <= 32'd0;
            rd_lane_q    <= 2'd0;
            rd_size_q    <= 2'd0;
            rd_signed_q  <= 1'b0;
            load_valid_q <= 1'b0;
            fault_q      <= 1'b0;
            fault_addr_q <= 32'd0;
        end else if (!StallW) begin
            load_valid_q <= load_valid_d;
            fault_q      <= fault_d;
            if (do_load) begin
                rd_word_q   <= mem_q[word_idx];
                rd_lane_q   <= lane;
                rd_size_q   <= MemSizeM;
                rd_signed_q <= MemSignedM;
            end
            if (fault_d) begin
                fault_addr_q <= ALUOutM;
            end
        end
    end

    // Extraction is applied to the held word, so ReadDataW holds with it
    always_comb begin
        sel_byte = rd_word_q[{rd_lane_q, 3'b000} +: 8];
        sel_half = rd_lane_q[1] ? rd_word_q[31:16] : rd_word_q[15:0];
        unique case (rd_size_q)
            2'b00:   ext_data = {{24{rd_signed_q & sel_byte[7]}}, sel_byte};
            2'b01:   ext_data = {{16{rd_signed_q & sel_half[15]}}, sel_half};
            default: ext_data = rd_word_q;
        endcase
    end

    assign ReadDataW  = ext_data;
    assign LoadValidW = load_valid_q;
    assign MemFaultW  = fault_q;
    assign FaultAddrW = fault_addr_q;

endmodule

// File: tb/tb_mem_stage_ext.sv
// Scoreboard bench for mem_stage_ext: directed stores/loads/faults push expected
// results; an independent monitor pops and compares whenever an output is produced.
module tb_mem_stage_ext;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemReqM;
    logic        MemWriteM;
    logic [1:0]  MemSizeM;
    logic        MemSignedM;
    logic [31:0] ALUOutM;
    logic [31:0] WriteDataM;
    logic        StallW;
    logic [31:0] ReadDataW;
    logic        LoadValidW;
    logic        MemFaultW;
    logic [31:0] FaultAddrW;

    typedef struct packed {
        logic        is_fault;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    mem_stage_ext #(.AW(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .MemReqM    (MemReqM),
        .MemWriteM  (MemWriteM),
        .MemSizeM   (MemSizeM),
        .MemSignedM (MemSignedM),
        .ALUOutM    (ALUOutM),
        .WriteDataM (WriteDataM),
        .StallW     (StallW),
        .ReadDataW  (ReadDataW),
        .LoadValidW (LoadValidW),
        .MemFaultW  (MemFaultW),
        .FaultAddrW (FaultAddrW)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change 2 time units after the edge, away from sampling
    task automatic drive(input logic req, input logic we, input logic [1:0] sz,
                         input logic sg, input logic [31:0] a, input logic [31:0] wd);
        MemReqM    = req;
        MemWriteM  = we;
        MemSizeM   = sz;
        MemSignedM = sg;
        ALUOutM    = a;
        WriteDataM = wd;
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic st(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        drive(1'b1, 1'b1, sz, 1'b0, a, wd);
    endtask

    task automatic ld(input logic [1:0] sz, input logic sg, input logic [31:0] a,
                      input logic [31:0] exp);
        sb.push_back('{is_fault: 1'b0, val: exp});
        drive(1'b1, 1'b0, sz, sg, a, 32'd0);
    endtask

    task automatic flt(input logic we, input logic [1:0] sz, input logic [31:0] a);
        sb.push_back('{is_fault: 1'b1, val: a});
        drive(1'b1, we, sz, 1'b0, a, 32'h5555_5555);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rdata"}, ReadDataW, 32'd0);
        chk({tag, "_lvalid"}, {31'd0, LoadValidW}, 32'd0);
        chk({tag, "_fault"}, {31'd0, MemFaultW}, 32'd0);
        chk({tag, "_faddr"}, FaultAddrW, 32'd0);
    endtask

    // Monitor: outputs are produced only on edges without stall or reset
    initial begin
        logic s, r;
        exp_t e;
        forever begin
            @(posedge clk);
            s = StallW;
            r = reset;
            #1;
            if (!s && !r && (LoadValidW || MemFaultW)) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_output: lvalid=%b fault=%b data=%h expected none",
                             LoadValidW, MemFaultW, ReadDataW);
                end else begin
                    e = sb.pop_front();
                    if (e.is_fault) begin
                        chk("fault_flag", {31'd0, MemFaultW}, 32'd1);
                        chk("fault_no_load", {31'd0, LoadValidW}, 32'd0);
                        chk("fault_addr", FaultAddrW, e.val);
                    end else begin
                        chk("load_valid", {31'd0, LoadValidW}, 32'd1);
                        chk("load_no_fault", {31'd0, MemFaultW}, 32'd0);
                        chk("load_data", ReadDataW, e.val);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation bound reached");
        $fatal(1);
    end

    initial begin
        reset      = 1'b1;
        StallW     = 1'b0;
        MemReqM    = 1'b0;
        MemWriteM  = 1'b0;
        MemSizeM   = 2'b00;
        MemSignedM = 1'b0;
        ALUOutM    = 32'd0;
        WriteDataM = 32'd0;
        repeat (2) @(posedge clk);
        #2;
        chk_zero("reset");
        reset = 1'b0;

        // Word store/load and valid clearing
        st(2'b10, 32'h10, 32'hDEAD_BEEF);
        ld(2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
        idle();
        chk("valid_clears", {31'd0, LoadValidW}, 32'd0);

        // Byte store into lane 1
        st(2'b00, 32'h11, 32'h0000_0080);
        ld(2'b10, 1'b0, 32'h10, 32'hDEAD_80EF);
        ld(2'b00, 1'b1, 32'h11, 32'hFFFF_FF80);
        ld(2'b00, 1'b0, 32'h11, 32'h0000_0080);

        // Half store into upper half
        st(2'b10, 32'h20, 32'h1234_5678);
        st(2'b10, 32'h14, 32'h0BAD_F00D);
        st(2'b01, 32'h22, 32'h0000_8001);
        ld(2'b01, 1'b1, 32'h22, 32'hFFFF_8001);
        ld(2'b01, 1'b0, 32'h22, 32'h0000_8001);
        ld(2'b10, 1'b0, 32'h20, 32'h8001_5678);
        ld(2'b01, 1'b1, 32'h20, 32'h0000_5678);

        // Misalignment and reserved size
        flt(1'b0, 2'b10, 32'h13);
        flt(1'b0, 2'b01, 32'h21);
        flt(1'b0, 2'b11, 32'h24);
        flt(1'b1, 2'b10, 32'h13);
        ld(2'b10, 1'b0, 32'h10, 32'hDEAD_80EF);
        ld(2'b10, 1'b0, 32'h14, 32'h0BAD_F00D);
        chk("fault_addr_hold", FaultAddrW, 32'h13);

        // Range: 0x1000 must not alias onto word 0
        st(2'b10, 32'h0, 32'h0102_0304);
        flt(1'b1, 2'b10, 32'h1000);
        ld(2'b10, 1'b0, 32'h0, 32'h0102_0304);
        st(2'b10, 32'hFFC, 32'hCAFE_F00D);
        ld(2'b10, 1'b0, 32'hFFC, 32'hCAFE_F00D);
        ld(2'b00, 1'b0, 32'hFFF, 32'h0000_00CA);

        // Stall holds outputs and blocks a presented store
        ld(2'b10, 1'b0, 32'h10, 32'hDEAD_80EF);
        StallW     = 1'b1;
        MemReqM    = 1'b1;
        MemWriteM  = 1'b1;
        MemSizeM   = 2'b10;
        ALUOutM    = 32'h10;
        WriteDataM = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #2;
            chk("stall_data", ReadDataW, 32'hDEAD_80EF);
            chk("stall_valid", {31'd0, LoadValidW}, 32'd1);
        end
        StallW = 1'b0;
        idle();
        ld(2'b10, 1'b0, 32'h10, 32'hDEAD_80EF);

        // Reset right after a load, with a store presented during reset
        ld(2'b10, 1'b0, 32'h14, 32'h0BAD_F00D);
        reset      = 1'b1;
        MemReqM    = 1'b1;
        MemWriteM  = 1'b1;
        MemSizeM   = 2'b10;
        ALUOutM    = 32'h20;
        WriteDataM = 32'hAAAA_AAAA;
        @(posedge clk);
        #2;
        chk_zero("mid_reset");
        reset = 1'b0;
        idle();
        ld(2'b10, 1'b0, 32'h20, 32'h8001_5678);
        idle();
        idle();

        n_vec++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
